// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NREQ requesters.
// It captures the winning byte and its parity settings, launches it, then follows tx_busy to the end of the frame.
`default_nettype none

module uart_tx_arbiter #(
  parameter int DWIDTH     = 8,
  parameter int NREQ       = 4,
  parameter int START_TO   = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*DWIDTH-1:0]    req_data,
  input  logic [NREQ-1:0]           req_parity_en,
  input  logic [NREQ-1:0]           req_parity_type,
  output logic [NREQ-1:0]           req_ack,
  output logic [DWIDTH-1:0]         tx_p_data,
  output logic                      tx_data_valid,
  output logic                      tx_parity_en,
  output logic                      tx_parity_type,
  input  logic                      tx_busy,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      ctrl_busy,
  output logic                      err_timeout
);

  localparam int IW   = $clog2(NREQ);
  localparam int TMAX = (START_TO > GAP_CYCLES) ? START_TO : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] START_LAST = TW'(START_TO - 1);
  localparam logic [TW-1:0] GAP_LAST   = (GAP_CYCLES > 0) ? TW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_GAP       = 3'd4
  } state_t;

  state_t            state;
  logic [IW-1:0]     last;
  logic [IW-1:0]     winner;
  logic [IW-1:0]     idx;
  logic              found;
  logic [TW-1:0]     timer;
  logic [DWIDTH-1:0] data_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*DWIDTH +: DWIDTH];
  end

  // Search starts one past the previous owner so a continuously requesting
  // client yields to every other pending client before being served again.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(last) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign ctrl_busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      last           <= IW'(NREQ - 1);
      timer          <= '0;
      req_ack        <= '0;
      tx_p_data      <= '0;
      tx_data_valid  <= 1'b0;
      tx_parity_en   <= 1'b0;
      tx_parity_type <= 1'b0;
      grant_id       <= '0;
      err_timeout    <= 1'b0;
    end else begin
      req_ack       <= '0;
      tx_data_valid <= 1'b0;
      err_timeout   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (found && !tx_busy) begin
            tx_p_data       <= data_arr[winner];
            tx_parity_en    <= req_parity_en[winner];
            tx_parity_type  <= req_parity_type[winner];
            grant_id        <= winner;
            last            <= winner;
            req_ack[winner] <= 1'b1;
            state           <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          tx_data_valid <= 1'b1;
          timer         <= '0;
          state         <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          // Busy wins over an expiring timer in the same cycle.
          if (tx_busy) begin
            state <= S_WAIT_DONE;
          end else if (timer == START_LAST) begin
            err_timeout <= 1'b1;
            state       <= S_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!tx_busy) begin
            timer <= '0;
            state <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          end
        end
        S_GAP: begin
          if (timer == GAP_LAST) begin
            state <= S_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed frames push expected launches,
// a negedge monitor pops and compares on every ack and tx_data_valid.
`default_nettype none

module tb_uart_tx_arbiter;

  localparam int START_TO   = 16;
  localparam int GAP_CYCLES = 2;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_parity_en;
  logic [3:0]  req_parity_type;
  logic [3:0]  req_ack;
  logic [7:0]  tx_p_data;
  logic        tx_data_valid;
  logic        tx_parity_en;
  logic        tx_parity_type;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        ctrl_busy;
  logic        err_timeout;

  logic        model_busy;
  logic        force_busy;
  logic        model_en;
  int          busy_delay;
  int          frame_len;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
    logic       pen;
    logic       ptype;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   failures;
  int   err_count;
  int   n;
  int   e0;
  int   nack;
  logic hold_ok;

  assign tx_busy = model_busy | force_busy;

  uart_tx_arbiter #(
    .DWIDTH(8), .NREQ(4), .START_TO(START_TO), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data),
    .req_parity_en(req_parity_en), .req_parity_type(req_parity_type),
    .req_ack(req_ack), .tx_p_data(tx_p_data), .tx_data_valid(tx_data_valid),
    .tx_parity_en(tx_parity_en), .tx_parity_type(tx_parity_type),
    .tx_busy(tx_busy), .grant_id(grant_id), .ctrl_busy(ctrl_busy),
    .err_timeout(err_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic expect_frame(input int id, input logic [7:0] d, input logic pen, input logic pt);
    exp_t e;
    e.id = 2'(id); e.data = d; e.pen = pen; e.ptype = pt;
    exp_q.push_back(e);
  endtask

  task automatic wait_ack(input int idx);
    int k;
    logic [3:0] m;
    k = 0;
    m = 4'b0001 << idx;
    @(negedge clk);
    while (req_ack == 4'b0000 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("ack_seen", 32'(req_ack), 32'(m));
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((ctrl_busy || tx_busy) && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("idle_reached", 32'({ctrl_busy, tx_busy}), 32'd0);
  endtask

  // Transmitter model: answers a launch with busy after busy_delay cycles.
  initial begin
    model_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_data_valid && model_en) begin
        repeat (busy_delay) @(negedge clk);
        model_busy = 1'b1;
        repeat (frame_len) @(negedge clk);
        model_busy = 1'b0;
      end
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst) begin
      if (req_ack != 4'b0000) begin
        check("ack_onehot", 32'($onehot(req_ack)), 32'd1);
        if (exp_q.size() > 0) check("ack_id", 32'(req_ack), 32'(4'b0001 << exp_q[0].id));
      end
      if (err_timeout) err_count++;
      if (tx_data_valid) begin
        if (exp_q.size() == 0) begin
          check("launch_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("launch_data", 32'(tx_p_data), 32'(e.data));
          check("launch_parity", 32'({tx_parity_en, tx_parity_type}), 32'({e.pen, e.ptype}));
          check("launch_grant", 32'(grant_id), 32'(e.id));
        end
      end
    end
  end

  initial begin
    checks = 0; failures = 0; err_count = 0;
    rst = 1'b1; req_valid = '0; req_data = '0; req_parity_en = '0; req_parity_type = '0;
    force_busy = 1'b0; model_en = 1'b1; busy_delay = 0; frame_len = 10;
    #3 rst = 1'b0;
    @(negedge clk);
    check("reset_ack", 32'(req_ack), 32'd0);
    check("reset_data", 32'(tx_p_data), 32'd0);
    check("reset_ctrl", 32'({tx_data_valid, tx_parity_en, tx_parity_type, grant_id, ctrl_busy, err_timeout}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Single frame from requester 0: latency, data hold and gap
    req_data[7:0] = 8'hA5; req_parity_en[0] = 1'b1; req_parity_type[0] = 1'b0;
    expect_frame(0, 8'hA5, 1'b1, 1'b0);
    req_valid = 4'b0001;
    @(negedge clk);
    check("t1_ack", 32'(req_ack), 32'h1);
    req_valid = 4'b0000;
    @(negedge clk);
    check("t1_launch", 32'(tx_data_valid), 32'd1);
    hold_ok = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      @(negedge clk);
      if (tx_p_data !== 8'hA5 || tx_parity_en !== 1'b1 || tx_parity_type !== 1'b0 || grant_id !== 2'd0)
        hold_ok = 1'b0;
      if (i == 12) check("t1_gap_busy", 32'(ctrl_busy), 32'd1);
      if (i == 13) check("t1_gap_done", 32'(ctrl_busy), 32'd0);
    end
    check("t1_hold", 32'(hold_ok), 32'd1);
    wait_idle();

    // All four requesting continuously from a fresh pointer
    @(negedge clk); rst = 1'b0; @(negedge clk); rst = 1'b1;
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    req_parity_en = 4'b1010; req_parity_type = 4'b0110;
    for (int r = 0; r < 2; r++) begin
      expect_frame(0, 8'h11, 1'b0, 1'b0);
      expect_frame(1, 8'h22, 1'b1, 1'b1);
      expect_frame(2, 8'h33, 1'b0, 1'b1);
      expect_frame(3, 8'h44, 1'b1, 1'b0);
    end
    req_valid = 4'b1111;
    nack = 0;
    for (int k = 0; k < 600 && nack < 8; k++) begin
      @(negedge clk);
      if (req_ack != 4'b0000) nack++;
    end
    req_valid = 4'b0000;
    check("rr_acks", 32'(nack), 32'd8);
    wait_idle();

    // Launch never answered: timeout, then requester 1 is served
    e0 = err_count;
    model_en = 1'b0;
    req_data[7:0] = 8'h5A; req_data[15:8] = 8'hC3;
    req_parity_en = 4'b0010; req_parity_type = 4'b0000;
    expect_frame(0, 8'h5A, 1'b0, 1'b0);
    expect_frame(1, 8'hC3, 1'b1, 1'b0);
    req_valid = 4'b0011;
    wait_ack(0);
    @(negedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!err_timeout && n < 40);
    check("timeout_latency", 32'(n), 32'(START_TO));
    check("timeout_idle", 32'(ctrl_busy), 32'd0);
    model_en = 1'b1;
    wait_ack(1);
    wait_idle();
    check("timeout_once", 32'(err_count - e0), 32'd1);

    // Busy rises exactly as the timer hits its last count
    e0 = err_count;
    busy_delay = START_TO - 1;
    req_data[23:16] = 8'h81; req_parity_en[2] = 1'b1; req_parity_type[2] = 1'b0;
    expect_frame(2, 8'h81, 1'b1, 1'b0);
    req_valid = 4'b0100;
    wait_ack(2);
    wait_idle();
    check("busy_beats_timeout", 32'(err_count - e0), 32'd0);
    busy_delay = 0;

    // Asynchronous reset in the middle of a frame
    req_data[7:0] = 8'h3C; req_parity_en[0] = 1'b0; req_parity_type[0] = 1'b1;
    expect_frame(0, 8'h3C, 1'b0, 1'b1);
    req_valid = 4'b0001;
    wait_ack(0);
    n = 0;
    while (!model_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("mid_frame_data", 32'(tx_p_data), 32'h3C);
    check("mid_frame_busy", 32'(ctrl_busy), 32'd1);
    rst = 1'b0;
    #1;
    check("rst_ack", 32'(req_ack), 32'd0);
    check("rst_data", 32'(tx_p_data), 32'd0);
    check("rst_ctrl", 32'({tx_data_valid, tx_parity_en, tx_parity_type, grant_id, ctrl_busy, err_timeout}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    wait_idle();
    req_data[7:0] = 8'h0F; req_data[15:8] = 8'hF0;
    req_parity_en[1:0] = 2'b01; req_parity_type[1:0] = 2'b10;
    expect_frame(0, 8'h0F, 1'b1, 1'b0);
    expect_frame(1, 8'hF0, 1'b0, 1'b1);
    req_valid = 4'b0011;
    wait_ack(0);
    wait_ack(1);
    wait_idle();

    // tx_busy high in IDLE blocks arbitration
    force_busy = 1'b1;
    req_data[23:16] = 8'h96; req_parity_en[2] = 1'b1; req_parity_type[2] = 1'b1;
    expect_frame(2, 8'h96, 1'b1, 1'b1);
    req_valid = 4'b0100;
    hold_ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (req_ack != 4'b0000 || ctrl_busy) hold_ok = 1'b0;
    end
    check("blocked_no_ack", 32'(hold_ok), 32'd1);
    force_busy = 1'b0;
    @(negedge clk);
    check("unblocked_ack", 32'(req_ack), 32'h4);
    req_valid = 4'b0000;
    wait_idle();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
